// File: rtl/prbs11_gen_g4.sv
// prbs11_gen_g4: Gen4 SLOS transmitter.
// Emits the 448-bit PRBS11 symbol-lock ordered set (x^11 + x^9 + 1) serially,
// one bit per clock, reseeding the LFSR at every ordered-set boundary.
// Bursts are either a fixed number of ordered sets or continuous until stop.
module prbs11_gen_g4 #(
    parameter bit lane0_lane1 = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] os_count,
    input  logic       stop,
    output logic       data_out,
    output logic       data_valid,
    output logic       os_start,
    output logic       busy,
    output logic       done
);

    localparam logic [10:0] SEED     = lane0_lane1 ? 11'h7FF : 11'h770;
    localparam logic [8:0]  LAST_BIT = 9'h1BF;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t      state, state_nx;
    logic [10:0] lfsr, lfsr_nx;
    logic [8:0]  bit_cnt, bit_cnt_nx;
    logic [7:0]  os_cnt, os_cnt_nx;
    logic [7:0]  os_len, os_len_nx;
    logic        stop_pend, stop_pend_nx;
    logic        last_bit;
    logic        burst_end;

    logic        data_out_nx;
    logic        data_valid_nx;
    logic        os_start_nx;
    logic        busy_nx;
    logic        done_nx;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= SEED;
            bit_cnt   <= '0;
            os_cnt    <= '0;
            os_len    <= '0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            lfsr      <= lfsr_nx;
            bit_cnt   <= bit_cnt_nx;
            os_cnt    <= os_cnt_nx;
            os_len    <= os_len_nx;
            stop_pend <= stop_pend_nx;
        end
    end

    // Next-state and datapath update; lfsr[10] is the bit currently on data_out.
    always_comb begin
        state_nx     = state;
        lfsr_nx      = lfsr;
        bit_cnt_nx   = bit_cnt;
        os_cnt_nx    = os_cnt;
        os_len_nx    = os_len;
        stop_pend_nx = stop_pend;
        last_bit     = (bit_cnt == LAST_BIT);
        // A stop seen on the final bit itself still ends at this boundary.
        burst_end    = ((os_len != 8'd0) && ((os_cnt + 8'd1) == os_len))
                       || stop_pend || stop;
        case (state)
            IDLE: begin
                stop_pend_nx = 1'b0;
                if (start) begin
                    state_nx   = SEND;
                    os_len_nx  = os_count;
                    os_cnt_nx  = '0;
                    lfsr_nx    = SEED;
                    bit_cnt_nx = '0;
                end
            end
            SEND: begin
                if (last_bit) begin
                    lfsr_nx    = SEED;
                    bit_cnt_nx = '0;
                    os_cnt_nx  = os_cnt + 8'd1;
                    if (burst_end) begin
                        state_nx     = DONE;
                        stop_pend_nx = 1'b0;
                    end
                end else begin
                    lfsr_nx      = {lfsr[9:0], lfsr[10] ^ lfsr[8]};
                    bit_cnt_nx   = bit_cnt + 9'd1;
                    stop_pend_nx = stop_pend | stop;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is registered.
    always_comb begin
        data_valid_nx = (state_nx == SEND);
        busy_nx       = (state_nx == SEND);
        done_nx       = (state_nx == DONE);
        os_start_nx   = data_valid_nx && (bit_cnt_nx == 9'd0);
        data_out_nx   = data_valid_nx && lfsr_nx[10];
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= 1'b0;
            data_valid <= 1'b0;
            os_start   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            data_out   <= data_out_nx;
            data_valid <= data_valid_nx;
            os_start   <= os_start_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

endmodule

// File: tb/tb_prbs11_gen_g4.sv
// Testbench for prbs11_gen_g4: both lane seeds run side by side on shared stimulus.
`timescale 1ns/1ps
module tb_prbs11_gen_g4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] os_count = 8'd0;

    // Index 1 = lane0_lane1=1 (seed 7FF), index 0 = lane0_lane1=0 (seed 770)
    logic [1:0] o_data, o_valid, o_os, o_busy, o_done;

    always #5 clk = ~clk;

    prbs11_gen_g4 #(.lane0_lane1(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .os_count(os_count), .stop(stop),
        .data_out(o_data[1]), .data_valid(o_valid[1]), .os_start(o_os[1]),
        .busy(o_busy[1]), .done(o_done[1])
    );

    prbs11_gen_g4 #(.lane0_lane1(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .os_count(os_count), .stop(stop),
        .data_out(o_data[0]), .data_valid(o_valid[0]), .os_start(o_os[0]),
        .busy(o_busy[0]), .done(o_done[0])
    );

    typedef struct packed {
        logic data;
        logic os;
    } exp_t;

    typedef struct {
        logic [7:0] cnt;
        int         stop_at;
        int         late_at;
        logic [7:0] late_cnt;
        int         exp_slos;
        string      name;
    } vec_t;

    exp_t        q[2][$];
    int          checks = 0;
    int          errors = 0;
    int          dcount[2] = '{0, 0};
    logic [11:0] sh[2];
    int unsigned nb[2] = '{13, 13};
    logic [11:0] exp12[2] = '{12'hEE0, 12'hFFE};
    vec_t        vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Reference PRBS11 model: push n ordered sets per lane.
    task automatic push_exp(input int n_slos);
        logic [10:0] l;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < n_slos; k++) begin
                l = (i == 1) ? 11'h7FF : 11'h770;
                for (int b = 0; b < 448; b++) begin
                    q[i].push_back('{data: l[10], os: (b == 0)});
                    l = {l[9:0], l[10] ^ l[8]};
                end
            end
        end
    endtask

    // Output monitor: pops the scoreboard on every valid bit.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (o_valid[i]) begin
                    if (q[i].size() == 0) begin
                        check("extra_valid_bit", 32'd1, 32'd0);
                    end else begin
                        e = q[i].pop_front();
                        check("data_out", o_data[i], e.data);
                        check("os_start", o_os[i], e.os);
                    end
                    check("busy_while_valid", o_busy[i], 1'b1);
                    if (o_os[i]) begin
                        sh[i] = {11'd0, o_data[i]};
                        nb[i] = 1;
                    end else if (nb[i] < 12) begin
                        sh[i] = {sh[i][10:0], o_data[i]};
                        nb[i]++;
                    end
                    if (nb[i] == 12) begin
                        check("first12_bits", sh[i], exp12[i]);
                        nb[i] = 13;
                    end
                end else begin
                    check("busy_low_when_invalid", o_busy[i], 1'b0);
                    check("data_low_when_invalid", o_data[i], 1'b0);
                    check("os_start_low_when_invalid", o_os[i], 1'b0);
                end
                if (o_done[i]) dcount[i]++;
            end
        end
    end

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 2; i++) begin
            check({name, "_data_out"}, o_data[i], 1'b0);
            check({name, "_data_valid"}, o_valid[i], 1'b0);
            check({name, "_os_start"}, o_os[i], 1'b0);
            check({name, "_busy"}, o_busy[i], 1'b0);
            check({name, "_done"}, o_done[i], 1'b0);
        end
    endtask

    // Called #1 after a rising edge; start is driven immediately.
    task automatic run_vec(input vec_t v);
        int total;
        int base[2];
        total = v.exp_slos * 448;
        base[0] = dcount[0];
        base[1] = dcount[1];
        start = 1'b1;
        os_count = v.cnt;
        push_exp(v.exp_slos);
        @(posedge clk); #1;
        os_count = 8'hAA;
        for (int n = 0; n < total; n++) begin
            stop = (n == v.stop_at);
            if (n == v.late_at) begin
                start = 1'b1;
                os_count = v.late_cnt;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check({v.name, "_done_pulse"}, o_done[i], 1'b1);
            check({v.name, "_valid_after_last"}, o_valid[i], 1'b0);
            check({v.name, "_busy_after_last"}, o_busy[i], 1'b0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            check({v.name, "_done_cleared"}, o_done[i], 1'b0);
            check({v.name, "_bits_left"}, q[i].size(), 32'd0);
            check({v.name, "_done_count"}, dcount[i] - base[i], 32'd1);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        vec_t v;
        int   left;
        int   dbase;

        vecs[0] = '{8'd1, -1,  -1,  8'd0, 1, "single"};
        vecs[1] = '{8'd3, -1,  -1,  8'd0, 3, "burst3"};
        vecs[2] = '{8'd0, 548, -1,  8'd0, 2, "cont_stop_bit100"};
        vecs[3] = '{8'd0, 895, -1,  8'd0, 2, "cont_stop_bit447"};
        vecs[4] = '{8'd1, -1,  200, 8'd5, 1, "start_while_busy"};
        vecs[5] = '{8'd2, 10,  -1,  8'd0, 1, "finite_stop"};

        // Asynchronous reset asserted mid-cycle
        #2 reset = 1'b1;
        #1 check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_all_zero("idle_after_reset");
        end

        foreach (vecs[k]) run_vec(vecs[k]);

        // Reset in the middle of a burst with a stop already pending
        dbase = dcount[1];
        start = 1'b1;
        os_count = 8'd3;
        push_exp(3);
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 300; n++) begin
            stop = (n == 100);
            @(posedge clk); #1;
        end
        stop = 1'b0;
        #1 reset = 1'b1;
        #1 check_all_zero("mid_burst_reset");
        for (int i = 0; i < 2; i++) begin
            left = q[i].size();
            check("bits_before_reset", left, 32'd1044);
            q[i].delete();
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_all_zero("idle_after_mid_reset");
        end
        check("no_done_on_reset", dcount[1] - dbase, 32'd0);
        v = '{8'd2, -1, -1, 8'd0, 2, "after_reset"};
        run_vec(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
